// File: rtl/mfp_ahb_botctrl.sv
// mfp_ahb_botctrl: AHB-Lite slave sequencing the RojoBot update/acknowledge handshake.
module mfp_ahb_botctrl #(
  parameter int INFO_W      = 32,
  parameter int CTRL_W      = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              HCLK,
  input  logic              SI_Reset,
  input  logic              HSEL,
  input  logic [3:0]        HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  input  logic [INFO_W-1:0] IO_BotInfo,
  input  logic              IO_BotUpdt_Sync,
  output logic [CTRL_W-1:0] IO_BotCtrl,
  output logic              IO_INT_ACK,
  output logic              IRQ
);
  typedef enum logic [1:0] {IDLE = 2'b00, PENDING = 2'b01, ACKING = 2'b10} state_t;
  state_t r_state, w_state;
  logic r_valid, r_write, r_updt_prev, r_ovr, r_to, r_ack;
  logic [1:0] r_addr;
  logic [31:0] r_hrdata;
  logic [INFO_W-1:0] r_snap;
  logic [CTRL_W-1:0] r_ctrl;
  logic [15:0] r_cnt, w_cnt;
  logic w_aphase, w_rise, w_pend, w_wr_ack, w_ack_req, w_clr_ovr, w_clr_to, w_ack_nxt, w_to_set;
  logic [31:0] w_status, w_rd;
  logic w_unused;
  assign w_unused  = ^{HWDATA, HADDR[1:0], HTRANS[0]};
  assign w_aphase  = HSEL & HTRANS[1] & HREADY;
  assign w_rise    = IO_BotUpdt_Sync & ~r_updt_prev;
  assign w_pend    = r_state == PENDING;
  assign w_wr_ack  = r_valid & r_write & (r_addr == 2'd3);
  assign w_ack_req = w_wr_ack & HWDATA[0];
  assign w_clr_ovr = w_wr_ack & HWDATA[1];
  assign w_clr_to  = w_wr_ack & HWDATA[2];
  assign w_status  = {27'd0, r_state, r_to, r_ovr, w_pend};
  // Read data is captured at the address-phase edge so it is stable for the whole data phase.
  assign w_rd = HADDR[3:2] == 2'd0 ? 32'(r_snap) :
                HADDR[3:2] == 2'd1 ? 32'(r_ctrl) :
                HADDR[3:2] == 2'd2 ? w_status : 32'd0;
  assign HRDATA     = r_hrdata;
  assign HREADYOUT  = 1'b1;
  assign HRESP      = 1'b0;
  assign IO_BotCtrl = r_ctrl;
  assign IO_INT_ACK = r_ack;
  assign IRQ        = w_pend;
  // A new bot update always wins over an acknowledge in flight.
  always_comb begin
    w_state   = r_state;
    w_ack_nxt = r_ack;
    w_cnt     = r_cnt;
    w_to_set  = 1'b0;
    if (w_rise) begin
      w_state   = PENDING;
      w_ack_nxt = 1'b0;
    end else if (w_pend && w_ack_req) begin
      w_state   = ACKING;
      w_ack_nxt = 1'b1;
      w_cnt     = 16'd0;
    end else if (r_state == ACKING) begin
      w_cnt = r_cnt + 16'd1;
      if (!IO_BotUpdt_Sync) begin
        w_state   = IDLE;
        w_ack_nxt = 1'b0;
      end else if (r_cnt == 16'(ACK_TIMEOUT - 1)) begin
        w_state   = IDLE;
        w_ack_nxt = 1'b0;
        w_to_set  = 1'b1;
      end
    end
  end
  always_ff @(posedge HCLK) begin
    if (SI_Reset) begin
      r_state     <= IDLE;
      r_valid     <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= 2'd0;
      r_hrdata    <= 32'd0;
      r_snap      <= '0;
      r_ctrl      <= '0;
      r_updt_prev <= 1'b0;
      r_ovr       <= 1'b0;
      r_to        <= 1'b0;
      r_ack       <= 1'b0;
      r_cnt       <= 16'd0;
    end else begin
      r_state     <= w_state;
      r_valid     <= w_aphase;
      r_write     <= w_aphase & HWRITE;
      r_addr      <= HADDR[3:2];
      r_hrdata    <= (w_aphase && !HWRITE) ? w_rd : 32'd0;
      r_updt_prev <= IO_BotUpdt_Sync;
      r_ovr       <= (w_rise & w_pend) | (r_ovr & ~w_clr_ovr);
      r_to        <= w_to_set | (r_to & ~w_clr_to);
      r_ack       <= w_ack_nxt;
      r_cnt       <= w_cnt;
      if (w_rise) r_snap <= IO_BotInfo;
      if (r_valid && r_write && r_addr == 2'd1) r_ctrl <= HWDATA[CTRL_W-1:0];
    end
  end
endmodule
